// File: rtl/coffee_vend_ctrl.sv
// rtl/coffee_vend_ctrl.sv - coin-credit coffee vending controller with vend, 5c change payout and cancel refund.
module coffee_vend_ctrl #(
   parameter int PRICE    = 3,
   parameter int CREDIT_W = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          coins,
   input  logic                cancel,
   output logic                coin_accept,
   output logic                coin_reject,
   output logic                coffee,
   output logic                change_coin,
   output logic [CREDIT_W-1:0] credit,
   output logic                busy
);

   localparam int MAX_CREDIT = 2**CREDIT_W - 1;
   localparam logic [CREDIT_W:0]   C_MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [CREDIT_W:0]   C_PRICE_W = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W-1:0] C_PRICE   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] C_ONE     = CREDIT_W'(1);

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_VEND    = 2'd1,
      S_CHANGE  = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] w_credit_next;
   logic                r_coffee;
   logic                r_change;
   logic                r_busy;
   logic [CREDIT_W:0]   w_coin_val;
   logic [CREDIT_W:0]   w_sum;
   logic                w_coin_present;
   logic                w_accept;
   logic                w_reject;

   always_comb begin
      case (coins)
         2'b01:   w_coin_val = (CREDIT_W+1)'(1);
         2'b10:   w_coin_val = (CREDIT_W+1)'(2);
         2'b11:   w_coin_val = (CREDIT_W+1)'(5);
         default: w_coin_val = '0;
      endcase
   end

   // One extra bit so an overflowing coin is detected instead of wrapping.
   assign w_sum          = {1'b0, r_credit} + w_coin_val;
   assign w_coin_present = (coins != 2'b00);

   always_comb begin
      w_next        = r_state;
      w_credit_next = r_credit;
      w_accept      = 1'b0;
      w_reject      = 1'b0;
      case (r_state)
         S_COLLECT: begin
            if (cancel && (r_credit != '0)) begin
               w_reject = w_coin_present;
               w_next   = S_CHANGE;
            end else if (w_coin_present) begin
               if (w_sum > C_MAX_W) begin
                  w_reject = 1'b1;
               end else begin
                  w_accept      = 1'b1;
                  w_credit_next = w_sum[CREDIT_W-1:0];
                  if (w_sum >= C_PRICE_W) w_next = S_VEND;
               end
            end
         end
         S_VEND: begin
            w_reject      = w_coin_present;
            w_credit_next = r_credit - C_PRICE;
            w_next        = (r_credit != C_PRICE) ? S_CHANGE : S_COLLECT;
         end
         S_CHANGE: begin
            // Leave on the pulse that pays out the last unit of credit.
            w_reject      = w_coin_present;
            w_credit_next = r_credit - C_ONE;
            w_next        = (r_credit == C_ONE) ? S_COLLECT : S_CHANGE;
         end
         default: begin
            w_next = S_COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_COLLECT;
         r_credit <= '0;
         r_coffee <= 1'b0;
         r_change <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_credit <= w_credit_next;
         r_coffee <= (w_next == S_VEND);
         r_change <= (w_next == S_CHANGE);
         r_busy   <= (w_next != S_COLLECT);
      end
   end

   assign coin_accept = w_accept;
   assign coin_reject = w_reject;
   assign coffee      = r_coffee;
   assign change_coin = r_change;
   assign credit      = r_credit;
   assign busy        = r_busy;

endmodule
